elevator: RTL and testbench

- Controller for a single 4-floor elevator car.
- Accepts a one-hot floor request and moves the car one floor at a time, using a fixed travel time per floor.
- Holds the door open for a fixed dwell time on arrival, then returns to idle.
- Output is the car's current floor, one-hot, for the floor indicator and upstream dispatch logic.

---
 rtl/elevator.sv | 108 ++++++++++
 tb/tb_elevator.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/elevator.sv
// Single-car, 4-floor elevator controller: one-floor-per-step travel with fixed
// travel and door dwell times. Define ELEVATOR_STATUS_EN for door/step-count status outputs.
module elevator #(
    parameter int unsigned FLOOR_TICKS = 10,
    parameter int unsigned DOOR_TICKS  = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req_floor,
    output logic [3:0] rec_floor
`ifdef ELEVATOR_STATUS_EN
    ,
    output logic       o_door_open,
    output logic [3:0] o_count
`endif
);

    localparam int unsigned MAX_TICKS = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
    localparam int unsigned TW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;

    state_t        state, state_nx;
    logic [1:0]    cur, cur_nx;
    logic [1:0]    tgt, tgt_nx;
    logic [TW-1:0] timer, timer_nx;
    logic          req_valid;
    logic [1:0]    req_idx;
    logic          step;

    always_comb begin
        req_valid = $onehot(req_floor);
        req_idx   = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (req_floor[i]) req_idx = 2'(i);
        end
    end

    always_comb begin
        state_nx = state;
        cur_nx   = cur;
        tgt_nx   = tgt;
        timer_nx = timer;
        step     = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid && (req_idx > cur)) begin
                    tgt_nx   = req_idx;
                    timer_nx = '0;
                    state_nx = MOVE_UP;
                end else if (req_valid && (req_idx < cur)) begin
                    tgt_nx   = req_idx;
                    timer_nx = '0;
                    state_nx = MOVE_DOWN;
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                if (timer == TW'(FLOOR_TICKS - 1)) begin
                    timer_nx = '0;
                    step     = 1'b1;
                    cur_nx   = (state == MOVE_UP) ? cur + 2'd1 : cur - 2'd1;
                    if (cur_nx == tgt) state_nx = DOOR_OPEN;
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end
            DOOR_OPEN: begin
                if (timer == TW'(DOOR_TICKS - 1)) begin
                    timer_nx = '0;
                    state_nx = IDLE;
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // rec_floor is loaded from the next floor so it updates on the same edge as cur
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur       <= '0;
            tgt       <= '0;
            timer     <= '0;
            rec_floor <= 4'b0001;
        end else begin
            state     <= state_nx;
            cur       <= cur_nx;
            tgt       <= tgt_nx;
            timer     <= timer_nx;
            rec_floor <= 4'(4'b0001 << cur_nx);
        end
    end

`ifdef ELEVATOR_STATUS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            o_door_open <= 1'b0;
            o_count     <= '0;
        end else begin
            o_door_open <= (state_nx == DOOR_OPEN);
            if (step) o_count <= o_count + 4'd1;
        end
    end
`endif

endmodule

// File: tb/tb_elevator.sv
// Bench for elevator: directed scenarios then random requests/resets, checked
// every cycle against a countdown-based trip model.
module tb_elevator;

    localparam int FT = 10;
    localparam int DT = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req_floor = 4'b0000;
    logic [3:0] rec_floor;
`ifdef ELEVATOR_STATUS_EN
    logic       o_door_open;
    logic [3:0] o_count;
`endif

    int errors = 0;
    int checks = 0;

    // model: phase 0 idle, 1 travelling, 2 door open; m_left = cycles remaining in phase
    int m_floor = 0, m_tgt = 0, m_phase = 0, m_left = 0, m_steps = 0;

    elevator #(.FLOOR_TICKS(FT), .DOOR_TICKS(DT)) dut (
        .clk(clk),
        .rst(rst),
        .req_floor(req_floor),
        .rec_floor(rec_floor)
`ifdef ELEVATOR_STATUS_EN
        ,
        .o_door_open(o_door_open),
        .o_count(o_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int n = 0, f = 0;
        for (int i = 0; i < 4; i++) if (req_floor[i]) begin n++; f = i; end
        if (rst) begin
            m_floor = 0; m_tgt = 0; m_phase = 0; m_left = 0; m_steps = 0;
        end else if (m_phase == 0) begin
            if (n == 1 && f != m_floor) begin
                m_tgt = f; m_phase = 1; m_left = FT;
            end
        end else if (m_phase == 1) begin
            m_left--;
            if (m_left == 0) begin
                m_floor += (m_tgt > m_floor) ? 1 : -1;
                m_steps = (m_steps + 1) % 16;
                if (m_floor == m_tgt) begin m_phase = 2; m_left = DT; end
                else m_left = FT;
            end
        end else begin
            m_left--;
            if (m_left == 0) m_phase = 0;
        end
    endtask

    task automatic tick();
        logic [3:0] exp_rec;
        @(posedge clk);
        model_edge();
        #1;
        exp_rec = 4'b0001 << m_floor;
        check("rec_floor", {4'h0, rec_floor}, {4'h0, exp_rec});
`ifdef ELEVATOR_STATUS_EN
        check("door_open", {7'h0, o_door_open}, {7'h0, m_phase == 2});
        check("count", {4'h0, o_count}, 8'(m_steps));
`endif
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int hold;
        int sel;
        logic [3:0] pat;

        // worked example: reset with req 0100 held, then trip 0 -> 2
        rst = 1'b1; req_floor = 4'b0100;
        tick();
        check("reset_floor", {4'h0, rec_floor}, 8'h01);
        rst = 1'b0;
        tick();                               // edge k: departs
        run(10);
        check("wk_k10", {4'h0, rec_floor}, 8'h02);
        run(10);
        check("wk_k20", {4'h0, rec_floor}, 8'h04);
`ifdef ELEVATOR_STATUS_EN
        check("wk_count2", {4'h0, o_count}, 8'h02);
`endif
        run(5);
        run(6);                               // request equals floor: stays put
        check("hold_same", {4'h0, rec_floor}, 8'h04);

        // floor 2 down to floor 0
        req_floor = 4'b0001;
        run(10);
        check("dn_10", {4'h0, rec_floor}, 8'h04);
        tick();
        check("dn_11", {4'h0, rec_floor}, 8'h02);
        run(10);
        check("dn_21", {4'h0, rec_floor}, 8'h01);
`ifdef ELEVATOR_STATUS_EN
        check("dn_count4", {4'h0, o_count}, 8'h04);
`endif
        run(5);

        // 0 -> 3 with request changed mid-trip
        req_floor = 4'b1000;
        run(15);
        req_floor = 4'b0001;
        run(16);
        check("up_top", {4'h0, rec_floor}, 8'h08);
        run(5 + 31);
        check("back_ground", {4'h0, rec_floor}, 8'h01);
        run(5);

        // invalid requests while idle
        req_floor = 4'b0000; run(5);
        req_floor = 4'b0110; run(5);
        check("invalid_still", {4'h0, rec_floor}, 8'h01);

        // reset between floors 1 and 2
        req_floor = 4'b0100;
        run(16);
        rst = 1'b1; req_floor = 4'b0000;
        tick();
        check("mid_reset", {4'h0, rec_floor}, 8'h01);
        rst = 1'b0;
        req_floor = 4'b0010;                  // cleared timer: exactly FT cycles to floor 1
        run(FT);
        check("post_reset_lat", {4'h0, rec_floor}, 8'h01);
        tick();
        check("post_reset_arr", {4'h0, rec_floor}, 8'h02);
        run(DT);

        // random requests, hold lengths and occasional resets
        for (int s = 0; s < 150; s++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7) pat = 4'b0001 << $urandom_range(0, 3);
            else         pat = 4'($urandom);
            req_floor = pat;
            rst = ($urandom_range(0, 39) == 0);
            tick();
            rst = 1'b0;
            hold = $urandom_range(1, 45);
            run(hold);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
